// File: rtl/pipe_stage_reg.sv
// Single pipeline register stage with valid/ready handshake, flush and a
// saturating back-pressure counter.
// Build option: define PIPE_STAGE_SKID_EN to add a skid entry. That build
// registers in_ready and removes the combinational out_ready -> in_ready path.
module pipe_stage_reg #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned RD_W    = 5,
  parameter int unsigned FLAGS_W = 17,
  parameter int unsigned CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_result,
  input  logic [RD_W-1:0]    in_rd,
  input  logic [FLAGS_W-1:0] in_flags,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_result,
  output logic [RD_W-1:0]    out_rd,
  output logic [FLAGS_W-1:0] out_flags,
  output logic [CNT_W-1:0]   stall_cnt
);

  typedef struct packed {
    logic [DATA_W-1:0]  result;
    logic [RD_W-1:0]    rd;
    logic [FLAGS_W-1:0] flags;
  } entry_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  entry_t in_entry;
  entry_t main_q;
  logic   main_valid_q;
  logic   in_fire;
  logic   out_fire;

  assign in_entry = '{result: in_result, rd: in_rd, flags: in_flags};
  assign out_fire = main_valid_q && out_ready;
  assign in_fire  = in_valid && in_ready;

`ifdef PIPE_STAGE_SKID_EN
  entry_t skid_q;
  logic   skid_valid_q;
  logic   in_ready_q;

  // in_ready is registered as "skid empty" so out_ready never reaches it combinationally
  assign in_ready = in_ready_q;

  // Main/skid storage: skid catches an input that arrives while main is stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_q <= 1'b0;
      main_q       <= '0;
      skid_valid_q <= 1'b0;
      skid_q       <= '0;
      in_ready_q   <= 1'b1;
    end else if (flush) begin
      main_valid_q <= 1'b0;
      main_q       <= '0;
      skid_valid_q <= 1'b0;
      skid_q       <= '0;
      in_ready_q   <= 1'b1;
    end else if (skid_valid_q) begin
      // in_ready is low here, so only draining is possible
      if (out_fire) begin
        main_q       <= skid_q;
        skid_valid_q <= 1'b0;
        skid_q       <= '0;
        in_ready_q   <= 1'b1;
      end
    end else if (in_fire) begin
      if (main_valid_q && !out_ready) begin
        skid_q       <= in_entry;
        skid_valid_q <= 1'b1;
        in_ready_q   <= 1'b0;
      end else begin
        main_q       <= in_entry;
        main_valid_q <= 1'b1;
      end
    end else if (out_fire) begin
      main_valid_q <= 1'b0;
      main_q       <= '0;
    end
  end
`else
  // Single entry: accept when empty or when the held entry leaves this edge
  assign in_ready = !main_valid_q || out_ready;

  // Main storage: a simultaneous in/out transfer replaces the held entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_q <= 1'b0;
      main_q       <= '0;
    end else if (flush) begin
      main_valid_q <= 1'b0;
      main_q       <= '0;
    end else if (in_fire) begin
      main_valid_q <= 1'b1;
      main_q       <= in_entry;
    end else if (out_fire) begin
      main_valid_q <= 1'b0;
      main_q       <= '0;
    end
  end
`endif

  // Count consecutive stalled cycles, saturating; holds while the stage is empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (flush || out_fire) begin
      stall_cnt <= '0;
    end else if (main_valid_q && !out_ready && (stall_cnt != CNT_MAX)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  // Payload registers are zeroed whenever invalid, so bubbles read as zero
  assign out_valid  = main_valid_q;
  assign out_result = main_q.result;
  assign out_rd     = main_q.rd;
  assign out_flags  = main_q.flags;

endmodule
